serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencer that time-multiplexes a single 1-bit full adder to perform WIDTH-bit add or subtract, one bit per clock, LSB first. It sits between a valid/ready operand producer and a valid/ready result consumer, and trades latency for area wherever a full ripple-carry adder is too large. It owns operand shifting, carry storage, bit counting, overflow detection and the handshakes.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- in_valid  in  1  operands a, b, sub are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- sub  in  1  0 = a+b, 1 = a−b.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For subtract this is the not-borrow flag: 1 means a ≥ b unsigned.
- ovf  out  1  signed overflow, equal to (carry into MSB) XOR cout.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready, load the a shift register ← a, load the b shift register ← (sub ? ~b : b), set carry ← sub, set cnt ← 0, then go to RUN.
  - Operands are captured only at the accept edge. Later changes on a, b or sub are ignored.
- **RUN**
  - Each cycle the full adder computes (s, c) = FA(a_sh[0], b_sh[0], carry).
  - Then: sum_sh ← {s, sum_sh[WIDTH-1:1]}, a_sh and b_sh shift right by 1, carry ← c, cnt ← cnt+1.
  - When cnt == WIDTH−1:
    - capture cout ← c;
    - capture ovf ← carry XOR c, where carry is the register value before the update, i.e. the carry into the MSB;
    - go to DONE.
- **DONE**
  - out_valid = 1; sum, cout and ovf are held stable.
  - On out_ready, go to IDLE.
- in_ready = 1 only in IDLE. in_valid is ignored in RUN and DONE.
- out_valid = 1 only in DONE.
- cnt width is $clog2(WIDTH); its terminal value is WIDTH−1. There is no wrap beyond that value.
- The result is modulo 2^WIDTH. Unsigned and signed interpretations share the same sum bits.

## Timing
- Reset values, asynchronous on rst_n low:
  - state = IDLE, so in_ready = 1, out_valid = 0 and busy = 0;
  - sum = 0, cout = 0, ovf = 0;
  - carry = 0, cnt = 0, all shift registers = 0.
- Reset asserted in RUN or DONE aborts the operation. The in-flight result is discarded and never presented.
- Latency: accept at edge E0 → out_valid high after edge E0+WIDTH, i.e. WIDTH cycles.
- Minimum initiation interval is WIDTH+2 cycles, with zero consumer backpressure:
  - one cycle in DONE;
  - one cycle in IDLE to re-accept.
- Backpressure: DONE holds indefinitely while out_ready = 0, with outputs constant.
- in_valid and out_ready may be asserted in the same cycle while in DONE. The output handshake completes and the input is not accepted until the next cycle (IDLE).
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Package serial_add_pkg holds the state encoding localparams: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- Sub-module: instantiate the existing full_adder as the 1-bit datapath. Carry, shift registers, counter and FSM stay in serial_add_ctrl.
- Expected size is ≈150–250 lines.

## Test plan
All scenarios use WIDTH = 8.
- **Add, signed overflow:** add 0x3C+0x5A → sum = 0x96, cout = 0, ovf = 1. out_valid rises exactly 8 cycles after accept.
- **Add, unsigned wrap:** add 0xFF+0x01 → sum = 0x00, cout = 1, ovf = 0.
- **Subtract, borrow:** subtract 0x10−0x20 → sum = 0xF0, cout = 0, ovf = 0.
- **Subtract, signed overflow:** subtract 0x80−0x01 → sum = 0x7F, cout = 1, ovf = 1.
- **Backpressure:**
  - Stimulus: hold out_ready = 0 for 5 cycles in DONE while toggling in_valid, a and b.
  - Required: sum, cout and ovf are constant; in_ready = 0; no accept occurs. The next accept happens only the cycle after the out handshake.
- **Reset mid-RUN:**
  - Stimulus: assert rst_n low 3 cycles after accept.
  - Required: outputs go to their reset values immediately; out_valid never pulses. A subsequent 0x01+0x01 yields 0x02.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// The state encoding is fixed so external checkers can decode state_dbg.
package serial_add_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_RUN  = RUN,
      S_DONE = DONE
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the only arithmetic element of the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one bit per clock, LSB first, through a
// single full adder; subtract is a + ~b + 1 with the +1 seeded into carry.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic [1:0]       state_dbg
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready/valid here depend only on registered state, never on the
   // partner's valid/ready, so the two handshakes cannot form a comb loop.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;
   assign sum       = sum_sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_c;
               if (cnt == CNT_LAST) begin
                  // carry still holds the carry into the MSB on this cycle
                  cout  <= fa_c;
                  ovf   <= carry ^ fa_c;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed checks of serial_add_ctrl at WIDTH = 8 with hand-computed results.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         busy;
   logic [1:0]   state_dbg;

   int n_assert = 0;
   int n_fail   = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands for one cycle; after the accept edge scramble the inputs
   // so a design that samples late would be caught.
   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
      @(negedge clk);
      check("in_ready_before_send", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      sub      = vs;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = W'($urandom_range(0, 255));
      b        = W'($urandom_range(0, 255));
      sub      = 1'($urandom_range(0, 1));
   endtask

   // Called #1 after the accept edge; expects out_valid exactly W edges later.
   task automatic wait_result(input string tag, input logic [W-1:0] es,
                              input logic ec, input logic eo);
      int cycles;
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check({tag, "_latency"}, 32'(cycles), 32'(W));
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
      check({tag, "_state_done"}, 32'(state_dbg), 32'd2);
   endtask

   task automatic release_out(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int pulses;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      send(8'h3C, 8'h5A, 1'b0);
      check("add_ovf_busy", 32'(busy), 32'd1);
      wait_result("add_ovf", 8'h96, 1'b0, 1'b1);
      release_out("add_ovf");

      send(8'hFF, 8'h01, 1'b0);
      wait_result("add_wrap", 8'h00, 1'b1, 1'b0);
      release_out("add_wrap");

      send(8'h10, 8'h20, 1'b1);
      wait_result("sub_borrow", 8'hF0, 1'b0, 1'b0);
      release_out("sub_borrow");

      send(8'h80, 8'h01, 1'b1);
      wait_result("sub_ovf", 8'h7F, 1'b1, 1'b1);
      release_out("sub_ovf");

      send(8'h55, 8'h55, 1'b1);
      wait_result("sub_equal", 8'h00, 1'b1, 1'b0);
      release_out("sub_equal");

      send(8'h7F, 8'h01, 1'b0);
      wait_result("add_pos_ovf", 8'h80, 1'b0, 1'b1);
      release_out("add_pos_ovf");

      // Backpressure: hold DONE while the producer keeps offering operands.
      send(8'h12, 8'h34, 1'b0);
      wait_result("bp", 8'h46, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a        = W'($urandom_range(0, 255));
         b        = W'($urandom_range(0, 255));
         @(posedge clk);
         #1;
         check("bp_sum_hold", 32'(sum), 32'h46);
         check("bp_cout_hold", 32'(cout), 32'd0);
         check("bp_ovf_hold", 32'(ovf), 32'd0);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      // Output handshake and a new offer in the same DONE cycle.
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = 8'h01;
      b         = 8'h02;
      sub       = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_handshake_idle", 32'(in_ready), 32'd1);
      check("bp_handshake_busy", 32'(busy), 32'd0);
      check("bp_handshake_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = 8'hEE;
      check("bp_next_accept_busy", 32'(busy), 32'd1);
      wait_result("bp_next", 8'h03, 1'b0, 1'b0);
      release_out("bp_next");

      // Reset three cycles after accept must abort the operation.
      send(8'hAA, 8'h11, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstrun_sum", 32'(sum), 32'd0);
      check("rstrun_cout", 32'(cout), 32'd0);
      check("rstrun_ovf", 32'(ovf), 32'd0);
      check("rstrun_busy", 32'(busy), 32'd0);
      check("rstrun_in_ready", 32'(in_ready), 32'd1);
      check("rstrun_out_valid", 32'(out_valid), 32'd0);
      pulses = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      check("rstrun_no_out_valid", 32'(pulses), 32'd0);

      send(8'h01, 8'h01, 1'b0);
      wait_result("after_rst", 8'h02, 1'b0, 1'b0);
      release_out("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
